// File: rtl/red_pitaya_dfilt_pkg.sv
// Shared definitions for the dfilt1 coefficient/flush controller.
package red_pitaya_dfilt_pkg;

  localparam int unsigned AaW   = 18;
  localparam int unsigned CoefW = 25;
  localparam int unsigned CntW  = 16;

  typedef enum logic [1:0] {
    StFlush  = 2'd0,
    StSettle = 2'd1,
    StRun    = 2'd2
  } dfilt_state_e;

  typedef enum logic [1:0] {
    SelAa = 2'd0,
    SelBb = 2'd1,
    SelKk = 2'd2,
    SelPp = 2'd3
  } dfilt_sel_e;

endpackage

// File: rtl/red_pitaya_dfilt1_coef_bank.sv
// Shadow and active coefficient registers; commit copies shadow to active.
module red_pitaya_dfilt1_coef_bank
  import red_pitaya_dfilt_pkg::*;
#(
  parameter logic [AaW-1:0]   AA_DEF = 18'h0,
  parameter logic [CoefW-1:0] BB_DEF = 25'h0,
  parameter logic [CoefW-1:0] KK_DEF = 25'hFFFFFF,
  parameter logic [CoefW-1:0] PP_DEF = 25'h0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_en_i,
  input  logic [1:0]              wr_sel_i,
  input  logic signed [CoefW-1:0] wr_dat_i,
  input  logic                    commit_i,
  output logic [AaW-1:0]          cfg_aa_o,
  output logic [CoefW-1:0]        cfg_bb_o,
  output logic [CoefW-1:0]        cfg_kk_o,
  output logic [CoefW-1:0]        cfg_pp_o
);

  logic [AaW-1:0]   sh_aa_q, sh_aa_d, act_aa_q, act_aa_d;
  logic [CoefW-1:0] sh_bb_q, sh_bb_d, act_bb_q, act_bb_d;
  logic [CoefW-1:0] sh_kk_q, sh_kk_d, act_kk_q, act_kk_d;
  logic [CoefW-1:0] sh_pp_q, sh_pp_d, act_pp_q, act_pp_d;

  // Shadow update; active set takes the post-write shadow so a same-cycle write is committed.
  always_comb begin
    sh_aa_d = sh_aa_q;
    sh_bb_d = sh_bb_q;
    sh_kk_d = sh_kk_q;
    sh_pp_d = sh_pp_q;
    if (wr_en_i) begin
      unique case (dfilt_sel_e'(wr_sel_i))
        SelAa: sh_aa_d = wr_dat_i[AaW-1:0];
        SelBb: sh_bb_d = wr_dat_i;
        SelKk: sh_kk_d = wr_dat_i;
        SelPp: sh_pp_d = wr_dat_i;
      endcase
    end
    act_aa_d = commit_i ? sh_aa_d : act_aa_q;
    act_bb_d = commit_i ? sh_bb_d : act_bb_q;
    act_kk_d = commit_i ? sh_kk_d : act_kk_q;
    act_pp_d = commit_i ? sh_pp_d : act_pp_q;
  end

  // Shadow and active registers, both restored to defaults on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_aa_q  <= AA_DEF;
      sh_bb_q  <= BB_DEF;
      sh_kk_q  <= KK_DEF;
      sh_pp_q  <= PP_DEF;
      act_aa_q <= AA_DEF;
      act_bb_q <= BB_DEF;
      act_kk_q <= KK_DEF;
      act_pp_q <= PP_DEF;
    end else begin
      sh_aa_q  <= sh_aa_d;
      sh_bb_q  <= sh_bb_d;
      sh_kk_q  <= sh_kk_d;
      sh_pp_q  <= sh_pp_d;
      act_aa_q <= act_aa_d;
      act_bb_q <= act_bb_d;
      act_kk_q <= act_kk_d;
      act_pp_q <= act_pp_d;
    end
  end

  assign cfg_aa_o = act_aa_q;
  assign cfg_bb_o = act_bb_q;
  assign cfg_kk_o = act_kk_q;
  assign cfg_pp_o = act_pp_q;

endmodule

// File: rtl/red_pitaya_dfilt1_ctrl.sv
// Coefficient commit controller for dfilt1: applies a shadow set, flushes the
// filter pipeline, waits for it to settle, then passes samples through.
// adc_rstn_i is expected to be released synchronously to adc_clk_i upstream.
module red_pitaya_dfilt1_ctrl
  import red_pitaya_dfilt_pkg::*;
#(
  parameter int unsigned      DW        = 14,
  parameter int unsigned      FLUSH_LEN = 4,
  parameter logic [AaW-1:0]   AA_DEF    = 18'h0,
  parameter logic [CoefW-1:0] BB_DEF    = 25'h0,
  parameter logic [CoefW-1:0] KK_DEF    = 25'hFFFFFF,
  parameter logic [CoefW-1:0] PP_DEF    = 25'h0
) (
  input  logic                    adc_clk_i,
  input  logic                    adc_rstn_i,
  input  logic                    wr_en_i,
  input  logic [1:0]              wr_sel_i,
  input  logic signed [CoefW-1:0] wr_dat_i,
  input  logic                    commit_i,
  input  logic [CntW-1:0]         cfg_settle_i,
  input  logic signed [DW-1:0]    filt_dat_i,
  output logic [AaW-1:0]          cfg_aa_o,
  output logic [CoefW-1:0]        cfg_bb_o,
  output logic [CoefW-1:0]        cfg_kk_o,
  output logic [CoefW-1:0]        cfg_pp_o,
  output logic                    filt_rstn_o,
  output logic signed [DW-1:0]    dat_o,
  output logic                    dat_vld_o,
  output logic                    busy_o,
  output logic                    commit_ack_o
);

  localparam logic [CntW-1:0] FlushLast = CntW'(FLUSH_LEN - 1);

  dfilt_state_e          state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [CntW-1:0]       settle_q, settle_d;
  logic                  frst_q, frst_d;
  logic signed [DW-1:0]  dat_q, dat_d;
  logic                  vld_q, vld_d;
  logic                  ack_q;

  red_pitaya_dfilt1_coef_bank #(
    .AA_DEF (AA_DEF),
    .BB_DEF (BB_DEF),
    .KK_DEF (KK_DEF),
    .PP_DEF (PP_DEF)
  ) u_coef_bank (
    .clk_i    (adc_clk_i),
    .rst_ni   (adc_rstn_i),
    .wr_en_i  (wr_en_i),
    .wr_sel_i (wr_sel_i),
    .wr_dat_i (wr_dat_i),
    .commit_i (commit_i),
    .cfg_aa_o (cfg_aa_o),
    .cfg_bb_o (cfg_bb_o),
    .cfg_kk_o (cfg_kk_o),
    .cfg_pp_o (cfg_pp_o)
  );

  // Saturating increment: the counter never wraps.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);

  // Next-state: FLUSH for FLUSH_LEN cycles, SETTLE for the length latched on FLUSH exit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    unique case (state_q)
      StFlush: begin
        if (cnt_q == FlushLast) begin
          cnt_d    = '0;
          settle_d = cfg_settle_i;
          state_d  = (cfg_settle_i == '0) ? StRun : StSettle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StSettle: begin
        if (cnt_q == settle_q - CntW'(1)) begin
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StRun: begin
        cnt_d = '0;
      end
      default: begin
        state_d = StFlush;
        cnt_d   = '0;
      end
    endcase
    // A commit always wins and restarts the flush; nothing is queued.
    if (commit_i) begin
      state_d = StFlush;
      cnt_d   = '0;
    end
  end

  // Output next-values: filter clear follows the next state, sample gate follows RUN.
  always_comb begin
    frst_d = (state_d != StFlush);
    vld_d  = (state_q == StRun) && !commit_i;
    dat_d  = vld_d ? filt_dat_i : dat_q;
  end

  // State, counter and output registers.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state_q  <= StFlush;
      cnt_q    <= '0;
      settle_q <= '0;
      frst_q   <= 1'b0;
      dat_q    <= '0;
      vld_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      frst_q   <= frst_d;
      dat_q    <= dat_d;
      vld_q    <= vld_d;
      ack_q    <= commit_i;
    end
  end

  assign filt_rstn_o  = frst_q;
  assign dat_o        = dat_q;
  assign dat_vld_o    = vld_q;
  assign busy_o       = (state_q != StRun);
  assign commit_ack_o = ack_q;

endmodule

// File: tb/tb_red_pitaya_dfilt1_ctrl.sv
// Self-checking bench for red_pitaya_dfilt1_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a cycle-age behavioural model.
module tb_red_pitaya_dfilt1_ctrl;

  localparam int unsigned FlushLen = 4;
  localparam int unsigned AgeCap   = 100000;
  localparam logic [24:0] AaDef    = 25'h0;
  localparam logic [24:0] BbDef    = 25'h0;
  localparam logic [24:0] KkDef    = 25'hFFFFFF;
  localparam logic [24:0] PpDef    = 25'h0;

  logic               adc_clk_i = 1'b0;
  logic               adc_rstn_i = 1'b0;
  logic               wr_en_i = 1'b0;
  logic [1:0]         wr_sel_i = 2'd0;
  logic signed [24:0] wr_dat_i = '0;
  logic               commit_i = 1'b0;
  logic [15:0]        cfg_settle_i = 16'd10;
  logic signed [13:0] filt_dat_i = '0;
  logic [17:0]        cfg_aa_o;
  logic [24:0]        cfg_bb_o, cfg_kk_o, cfg_pp_o;
  logic               filt_rstn_o, dat_vld_o, busy_o, commit_ack_o;
  logic signed [13:0] dat_o;

  red_pitaya_dfilt1_ctrl dut (
    .adc_clk_i    (adc_clk_i),
    .adc_rstn_i   (adc_rstn_i),
    .wr_en_i      (wr_en_i),
    .wr_sel_i     (wr_sel_i),
    .wr_dat_i     (wr_dat_i),
    .commit_i     (commit_i),
    .cfg_settle_i (cfg_settle_i),
    .filt_dat_i   (filt_dat_i),
    .cfg_aa_o     (cfg_aa_o),
    .cfg_bb_o     (cfg_bb_o),
    .cfg_kk_o     (cfg_kk_o),
    .cfg_pp_o     (cfg_pp_o),
    .filt_rstn_o  (filt_rstn_o),
    .dat_o        (dat_o),
    .dat_vld_o    (dat_vld_o),
    .busy_o       (busy_o),
    .commit_ack_o (commit_ack_o)
  );

  always #5 adc_clk_i = ~adc_clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: outputs follow from the number of cycles since the last
  // flush start (commit edge or reset) and the settle length taken at flush end.
  logic [24:0]        m_sh [4];
  logic [24:0]        m_act [4];
  int unsigned        m_age;
  int unsigned        m_set;
  logic signed [13:0] m_dat;
  logic               m_vld, m_ack;

  always @(posedge adc_clk_i or negedge adc_rstn_i) begin : model
    logic [24:0] nsh [4];
    logic        run_now;
    if (!adc_rstn_i) begin
      m_sh  <= '{AaDef, BbDef, KkDef, PpDef};
      m_act <= '{AaDef, BbDef, KkDef, PpDef};
      m_age <= 0;
      m_set <= 0;
      m_dat <= '0;
      m_vld <= 1'b0;
      m_ack <= 1'b0;
    end else begin
      nsh = m_sh;
      if (wr_en_i) nsh[wr_sel_i] = (wr_sel_i == 2'd0) ? {7'b0, wr_dat_i[17:0]} : wr_dat_i;
      run_now = (m_age >= FlushLen + m_set);
      m_vld <= run_now && !commit_i;
      if (run_now && !commit_i) m_dat <= filt_dat_i;
      m_ack <= commit_i;
      m_sh  <= nsh;
      if (commit_i) begin
        m_act <= nsh;
        m_age <= 0;
      end else begin
        if (m_age == FlushLen - 1) m_set <= cfg_settle_i;
        if (m_age < AgeCap) m_age <= m_age + 1;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge adc_clk_i) begin
    check("cfg_aa", cfg_aa_o, m_act[0]);
    check("cfg_bb", cfg_bb_o, m_act[1]);
    check("cfg_kk", cfg_kk_o, m_act[2]);
    check("cfg_pp", cfg_pp_o, m_act[3]);
    check("filt_rstn", filt_rstn_o, m_age >= FlushLen);
    check("busy", busy_o, !(m_age >= FlushLen + m_set));
    check("dat_vld", dat_vld_o, m_vld);
    check("dat", dat_o, m_dat);
    check("commit_ack", commit_ack_o, m_ack);
    if (commit_ack_o) ack_total++;
  end

  // Free-running sample source.
  always @(posedge adc_clk_i) begin
    #1 filt_dat_i = 14'($urandom);
  end

  task automatic tick();
    @(posedge adc_clk_i);
    #1;
  endtask

  task automatic do_commit();
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
  endtask

  // Count filter-clear and busy cycles until busy drops, with a cycle budget.
  task automatic measure(output int nlow, output int nbusy);
    bit done;
    nlow  = 0;
    nbusy = 0;
    done  = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge adc_clk_i);
      if (!busy_o) done = 1'b1;
      else begin
        nbusy++;
        if (!filt_rstn_o) nlow++;
      end
    end
    check("measure_timeout", done, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl, nb, ack_base;
    logic signed [13:0] held;

    // Reset state and release.
    repeat (3) tick();
    check("rst_filt_rstn", filt_rstn_o, 1'b0);
    check("rst_busy", busy_o, 1'b1);
    check("rst_vld", dat_vld_o, 1'b0);
    check("rst_kk", cfg_kk_o, 25'hFFFFFF);
    adc_rstn_i = 1'b1;
    measure(nl, nb);
    check("rel_flush_len", nl, 4);
    check("rel_busy_len", nb, 14);
    @(negedge adc_clk_i);
    check("rel_vld", dat_vld_o, 1'b1);
    check("rel_kk", cfg_kk_o, 25'hFFFFFF);

    // Shadow writes then commit; held sample during flush/settle.
    tick();
    wr_en_i = 1'b1; wr_sel_i = 2'd0; wr_dat_i = 25'h1234;
    tick();
    wr_sel_i = 2'd1; wr_dat_i = 25'h4000;
    tick();
    wr_en_i = 1'b0;
    check("shadow_no_leak_aa", cfg_aa_o, 18'h0);
    check("shadow_no_leak_bb", cfg_bb_o, 25'h0);
    held = dat_o;
    ack_base = ack_total;
    do_commit();
    check("commit_aa", cfg_aa_o, 18'h1234);
    check("commit_bb", cfg_bb_o, 25'h4000);
    measure(nl, nb);
    check("c1_flush_len", nl, 4);
    check("c1_busy_len", nb, 14);
    check("hold_dat", dat_o, held);
    tick(); tick();
    check("c1_ack_count", ack_total - ack_base, 1);

    // Same-cycle write and commit.
    wr_en_i = 1'b1; wr_sel_i = 2'd1; wr_dat_i = 25'h10; commit_i = 1'b1;
    tick();
    wr_en_i = 1'b0; commit_i = 1'b0;
    check("wc_bb", cfg_bb_o, 25'h10);
    check("wc_aa", cfg_aa_o, 18'h1234);
    measure(nl, nb);

    // Commit at SETTLE count 5, then again.
    tick();
    ack_base = ack_total;
    do_commit();
    repeat (9) tick();
    check("mid_settle_busy", busy_o, 1'b1);
    check("mid_settle_frst", filt_rstn_o, 1'b1);
    do_commit();
    measure(nl, nb);
    check("restart_flush_len", nl, 4);
    check("restart_busy_len", nb, 14);
    tick();
    check("restart_ack_count", ack_total - ack_base, 2);

    // Zero settle: RUN reached FLUSH_LEN cycles after the commit edge.
    cfg_settle_i = 16'd0;
    tick();
    do_commit();
    measure(nl, nb);
    check("zs_flush_len", nl, 4);
    check("zs_busy_len", nb, 4);
    @(negedge adc_clk_i);
    check("zs_vld", dat_vld_o, 1'b1);
    cfg_settle_i = 16'd10;

    // Reset mid-SETTLE discards the applied set.
    tick();
    wr_en_i = 1'b1; wr_sel_i = 2'd3; wr_dat_i = 25'h155; commit_i = 1'b1;
    tick();
    wr_en_i = 1'b0; commit_i = 1'b0;
    check("pre_rst_pp", cfg_pp_o, 25'h155);
    repeat (7) tick();
    adc_rstn_i = 1'b0;
    #2;
    check("arst_aa", cfg_aa_o, 18'h0);
    check("arst_bb", cfg_bb_o, 25'h0);
    check("arst_kk", cfg_kk_o, 25'hFFFFFF);
    check("arst_pp", cfg_pp_o, 25'h0);
    check("arst_frst", filt_rstn_o, 1'b0);
    check("arst_busy", busy_o, 1'b1);
    tick(); tick();
    adc_rstn_i = 1'b1;
    measure(nl, nb);
    check("rel2_flush_len", nl, 4);
    check("rel2_busy_len", nb, 14);
    @(negedge adc_clk_i);
    check("rel2_vld", dat_vld_o, 1'b1);
    check("rel2_kk", cfg_kk_o, 25'hFFFFFF);

    // Randomized traffic checked by the model every cycle.
    tick();
    for (int i = 0; i < 3000; i++) begin
      wr_en_i  = ($urandom_range(0, 9) < 3);
      wr_sel_i = 2'($urandom);
      wr_dat_i = 25'($urandom);
      commit_i = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 19) == 0) cfg_settle_i = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 499) == 0) begin
        adc_rstn_i = 1'b0;
        tick(); tick();
        adc_rstn_i = 1'b1;
      end
      tick();
    end
    wr_en_i  = 1'b0;
    commit_i = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
